// File: rtl/early_debouncer.sv
// Early-detection switch debouncer: the first synchronized edge of sw is passed straight through,
// then the input is ignored for a hold window of WAIT_TICKS external tick pulses.
module early_debouncer #(
    parameter int WAIT_TICKS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic tick,
    output logic db_level,
    output logic db_rise,
    output logic db_fall,
    output logic busy
);

    localparam int CW = $clog2(WAIT_TICKS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sw_s;

    // NOTE: the synchronizer flops are reset too, so a held switch must re-propagate after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sw};
        end
    end

    assign sw_s = sync[SYNC_STAGES-1];

    // NOTE: all state and outputs are updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ZERO;
            count    <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            db_rise <= 1'b0;
            db_fall <= 1'b0;
            case (state)
                ZERO: begin
                    count <= '0;
                    if (sw_s) begin
                        state    <= WAIT1;
                        db_level <= 1'b1;
                        db_rise  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT1: begin
                    if (tick) begin
                        if (count == LAST_COUNT) begin
                            state <= ONE;
                            count <= '0;
                            busy  <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ONE: begin
                    count <= '0;
                    if (!sw_s) begin
                        state    <= WAIT0;
                        db_level <= 1'b0;
                        db_fall  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT0: begin
                    if (tick) begin
                        if (count == LAST_COUNT) begin
                            state <= ZERO;
                            count <= '0;
                            busy  <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    // Unknown encoding recovers to the idle low state.
                    state    <= ZERO;
                    count    <= '0;
                    db_level <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_early_debouncer.sv
// Bench for early_debouncer: scenario tasks compare the DUT each cycle against a
// level/remaining-ticks reference model, plus scenario-specific timing checks.
module tb_early_debouncer;

    localparam int WT = 4;
    localparam int SS = 2;
    localparam int M  = 10;

    logic clk = 1'b0;
    logic reset;
    logic sw;
    logic tick;
    logic db_level, db_rise, db_fall, busy;
    logic [3:0] outs;

    int total = 0;
    int bad   = 0;

    int tick_cnt  = 0;
    bit tick_high = 1'b0;

    // Reference model: debounced level, whether a hold is in progress and ticks still to wait.
    logic [SS-1:0] m_sync;
    bit m_level, m_hold, m_rise, m_fall;
    int m_rem;

    early_debouncer #(.WAIT_TICKS(WT), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .tick     (tick),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall),
        .busy     (busy)
    );

    assign outs = {db_level, db_rise, db_fall, busy};

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_out();
        return {m_level, m_rise, m_fall, m_hold};
    endfunction

    task automatic model_reset();
        m_sync  = '0;
        m_level = 1'b0;
        m_hold  = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_rem   = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then move the tick generator.
    task automatic step();
        logic sw_s_m;
        @(posedge clk);
        if (!reset) begin
            sw_s_m = m_sync[SS-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_hold) begin
                if (tick) begin
                    m_rem--;
                    if (m_rem == 0) m_hold = 1'b0;
                end
            end else if (sw_s_m != m_level) begin
                m_level = ~m_level;
                m_hold  = 1'b1;
                m_rem   = WT;
                if (m_level) m_rise = 1'b1;
                else         m_fall = 1'b1;
            end
            m_sync = {m_sync[SS-2:0], sw};
        end
        #1;
        tick_cnt = (tick_cnt + 1) % M;
        tick = tick_high ? 1'b1 : (tick_cnt == M - 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw    = 1'b0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
        end
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_final got=%b want=0000", outs);
        end
    endtask

    task automatic test_clean_press();
        int rise_n = 0, fall_n = 0, rise_at = -1, busy_n = 0;
        sw = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
            if (db_rise) begin rise_n++; if (rise_at < 0) rise_at = k; end
            if (db_fall) fall_n++;
            if (busy) busy_n++;
        end
        total++;
        if (rise_n !== 1 || rise_at !== SS + 1 || fall_n !== 0) begin
            bad++;
            $display("FAIL clean_press_strobes rises=%0d at=%0d falls=%0d want 1 at %0d, 0", rise_n, rise_at, fall_n, SS + 1);
        end
        total++;
        if (busy_n < (WT - 1) * M + 1 || busy_n > WT * M || db_level !== 1'b1) begin
            bad++;
            $display("FAIL clean_press_window busy=%0d level=%b want %0d..%0d, 1", busy_n, db_level, (WT - 1) * M + 1, WT * M);
        end
    endtask

    task automatic test_bouncy_release();
        int fall_n = 0, rise_n = 0, fall_at = -1;
        bit rose = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            sw = (k <= 25) ? (((k - 1) / 3) % 2 == 1) : 1'b0;
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL bouncy_release cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
            if (db_fall) begin fall_n++; if (fall_at < 0) fall_at = k; end
            if (db_rise) rise_n++;
            if (fall_at > 0 && db_level) rose = 1'b1;
        end
        total++;
        if (fall_n !== 1 || fall_at !== SS + 1 || rise_n !== 0 || rose) begin
            bad++;
            $display("FAIL bouncy_release_strobes falls=%0d at=%0d rises=%0d relevel=%0d want 1 at %0d, 0, 0", fall_n, fall_at, rise_n, rose, SS + 1);
        end
    endtask

    task automatic test_bouncy_press();
        int rise_n = 0, fall_n = 0, rise_at = -1;
        bit dropped = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            sw = (k <= 25) ? (((k - 1) / 3) % 2 == 0) : 1'b1;
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL bouncy_press cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
            if (db_rise) begin rise_n++; if (rise_at < 0) rise_at = k; end
            if (db_fall) fall_n++;
            if (rise_at > 0 && !db_level) dropped = 1'b1;
        end
        total++;
        if (rise_n !== 1 || rise_at !== SS + 1 || fall_n !== 0 || dropped) begin
            bad++;
            $display("FAIL bouncy_press_strobes rises=%0d at=%0d falls=%0d dropped=%0d want 1 at %0d, 0, 0", rise_n, rise_at, fall_n, dropped, SS + 1);
        end
    endtask

    task automatic test_glitch();
        int rise_n = 0, fall_n = 0, rise_at = -1, fall_at = -1, busy_end = -1;
        sw = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL glitch_settle cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
        end
        for (int k = 1; k <= 100; k++) begin
            sw = (k <= 5);
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
            if (db_rise) begin rise_n++; if (rise_at < 0) rise_at = k; end
            if (db_fall) begin fall_n++; if (fall_at < 0) fall_at = k; end
            if (rise_at > 0 && busy_end < 0 && !busy) busy_end = k;
        end
        total++;
        if (rise_n !== 1 || fall_n !== 1 || rise_at !== SS + 1 || fall_at !== busy_end + 1 || db_level !== 1'b0) begin
            bad++;
            $display("FAIL glitch_strobes rises=%0d falls=%0d rise_at=%0d fall_at=%0d busy_end=%0d level=%b", rise_n, fall_n, rise_at, fall_at, busy_end, db_level);
        end
    endtask

    task automatic test_tick_high();
        int busy_n;
        tick_high = 1'b1;
        tick = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            busy_n = 0;
            sw = (phase == 0);
            for (int k = 1; k <= 30; k++) begin
                step();
                total++;
                if (outs !== exp_out()) begin
                    bad++;
                    $display("FAIL tick_high cyc=%0d got=%b want=%b", k, outs, exp_out());
                end
                if (busy) busy_n++;
            end
            total++;
            if (busy_n !== WT) begin
                bad++;
                $display("FAIL tick_high_window phase=%0d busy=%0d want %0d", phase, busy_n, WT);
            end
        end
        tick_high = 1'b0;
    endtask

    task automatic test_reset_mid_window();
        int guard = 0, rise_n = 0, rise_at = -1, busy_n = 0;
        sw = 1'b1;
        while (!(m_hold && m_rem == WT - 2) && guard < 100) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL mid_window_reach got=timeout want count=2");
        end
        reset = 1'b1;
        #1;
        total++;
        if (outs !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b want=0000", outs);
        end
        model_reset();
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=%b want=%b", k, outs, exp_out());
            end
            if (db_rise) begin rise_n++; if (rise_at < 0) rise_at = k; end
            if (busy) busy_n++;
        end
        total++;
        if (rise_n !== 1 || rise_at !== SS + 1 || busy_n < (WT - 1) * M + 1 || busy_n > WT * M) begin
            bad++;
            $display("FAIL after_reset_window rises=%0d at=%0d busy=%0d want 1 at %0d, %0d..%0d", rise_n, rise_at, busy_n, SS + 1, (WT - 1) * M + 1, WT * M);
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        bit prev_rise = 1'b0, prev_fall = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            if (hold_left == 0) begin
                sw = $urandom_range(0, 1);
                hold_left = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90) : $urandom_range(1, 8);
            end
            hold_left--;
            if ($urandom_range(0, 499) == 0) tick_cnt = $urandom_range(0, M - 1);
            step();
            total++;
            if (outs !== exp_out()) begin
                bad++;
                $display("FAIL random cyc=%0d sw=%b got=%b want=%b", k, sw, outs, exp_out());
            end
            total++;
            if ((db_rise && db_fall) || (db_rise && prev_rise) || (db_fall && prev_fall)) begin
                bad++;
                $display("FAIL strobe_exclusive cyc=%0d rise=%b fall=%b prev=%b%b want no overlap", k, db_rise, db_fall, prev_rise, prev_fall);
            end
            prev_rise = db_rise;
            prev_fall = db_fall;
        end
    endtask

    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        tick  = 1'b0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bouncy_release();
        test_bouncy_press();
        test_glitch();
        test_tick_high();
        test_reset_mid_window();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
